// File: rtl/bypass_track_unit.sv
// -----------------------------------------------------------------------------
// bypass_track_unit
//
// Forwarding and hazard unit for the pipelined core. It keeps a shift-register
// scoreboard of destination registers for DEPTH stages past EX (stage 1 = MEM,
// stage 2 = WB, ...). From that scoreboard it drives the per-operand forward
// selects for the instruction in EX. It also raises a load-use stall for the
// instruction in decode.
//
// Optional feature: define BYPASS_STALL_CNT_EN to add o_stall_count. This is a
// saturating 32-bit count of cycles with o_stall=1, cleared by reset.
//
// Ports
//   i_clock        system clock, rising edge
//   i_reset_n      asynchronous active-low reset
//   i_issue_valid  valid instruction in EX this cycle
//   i_issue_rd     destination register of the EX instruction
//   i_issue_regw   EX instruction writes the register file
//   i_issue_load   EX instruction is a load (result ready only after MEM)
//   i_flush        kill the EX/decode instructions this cycle
//   i_rs_ex        EX sources, operand i at [i*REG_W +: REG_W]
//   i_rs_dec       decode sources, same packing
//   o_fwd_sel      per operand: 0 = register file, k = tracked stage k
//   o_stall        hold PC/IF/ID and insert a bubble into EX
//   o_stall_count  (BYPASS_STALL_CNT_EN only) saturating stall-cycle count
// -----------------------------------------------------------------------------
module bypass_track_unit #(
    parameter int REG_W   = 5,
    parameter int DEPTH   = 2,
    parameter int NUM_SRC = 2,
    parameter int SEL_W   = 2
) (
    input  logic                       i_clock,
    input  logic                       i_reset_n,
    input  logic                       i_issue_valid,
    input  logic [REG_W-1:0]           i_issue_rd,
    input  logic                       i_issue_regw,
    input  logic                       i_issue_load,
    input  logic                       i_flush,
    input  logic [NUM_SRC*REG_W-1:0]   i_rs_ex,
    input  logic [NUM_SRC*REG_W-1:0]   i_rs_dec,
    output logic [NUM_SRC*SEL_W-1:0]   o_fwd_sel,
    output logic                       o_stall
`ifdef BYPASS_STALL_CNT_EN
    ,
    output logic [31:0]                o_stall_count
`endif
);

    // Scoreboard. Index 1 is the youngest entry (the MEM stage).
    logic [DEPTH:1]   r_v;
    logic [DEPTH:1]   r_regw;
    logic [DEPTH:1]   r_load;
    logic [REG_W-1:0] r_rd [1:DEPTH];

    logic [NUM_SRC*SEL_W-1:0] w_fwd_sel;
    logic [NUM_SRC-1:0]       w_fwd_load;
    logic                     w_load_hazard;
    logic [REG_W-1:0]         w_src;
    logic                     w_dec_hit;
    logic                     w_stall;

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_v    <= '0;
            r_regw <= '0;
            r_load <= '0;
            for (int k = 1; k <= DEPTH; k++) begin
                r_rd[k] <= '0;
            end
        end else begin
            // The scoreboard shifts every cycle, stall or not. The EX bubble
            // that follows a stall arrives here as i_issue_valid=0.
            r_v[1]    <= i_issue_valid & ~i_flush;
            r_regw[1] <= i_issue_regw;
            r_load[1] <= i_issue_load;
            r_rd[1]   <= i_issue_rd;
            for (int k = 2; k <= DEPTH; k++) begin
                r_v[k]    <= r_v[k-1];
                r_regw[k] <= r_regw[k-1];
                r_load[k] <= r_load[k-1];
                r_rd[k]   <= r_rd[k-1];
            end
        end
    end

    // Walk the stages from oldest to youngest, so the youngest match wins.
    // x0 is never forwarded, and neither is any entry with regw=0.
    always_comb begin
        w_fwd_sel     = '0;
        w_fwd_load    = '0;
        w_load_hazard = 1'b0;
        w_src         = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            w_src = i_rs_ex[i*REG_W +: REG_W];
            for (int k = DEPTH; k >= 1; k--) begin
                if (r_v[k] && r_regw[k] && (r_rd[k] == w_src) && (w_src != '0)) begin
                    w_fwd_sel[i*SEL_W +: SEL_W] = SEL_W'(k);
                    w_fwd_load[i]               = r_load[k];
                end
            end
            // A load's data does not exist yet while the load sits in MEM.
            // The select still reports 1. A correct stall sequence never
            // reaches this case.
            if ((w_fwd_sel[i*SEL_W +: SEL_W] == SEL_W'(1)) && w_fwd_load[i]) begin
                w_load_hazard = 1'b1;
            end
        end
    end

    always_comb begin
        w_dec_hit = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (i_rs_dec[i*REG_W +: REG_W] == i_issue_rd) begin
                w_dec_hit = 1'b1;
            end
        end
    end

    // Flush wins over stall. Both outputs are forced low while reset is held.
    assign w_stall = i_reset_n & i_issue_valid & i_issue_regw & i_issue_load &
                     (i_issue_rd != '0) & w_dec_hit & ~i_flush;

    assign o_stall   = w_stall;
    assign o_fwd_sel = i_reset_n ? w_fwd_sel : '0;

`ifdef BYPASS_STALL_CNT_EN
    logic [31:0] r_stall_count;

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_stall_count <= '0;
        end else if (w_stall && (r_stall_count != 32'hFFFF_FFFF)) begin
            r_stall_count <= r_stall_count + 32'd1;
        end
    end

    assign o_stall_count = r_stall_count;
`endif

`ifndef SYNTHESIS
    a_no_load_fwd_from_mem: assert property (
        @(posedge i_clock) disable iff (!i_reset_n) !w_load_hazard
    );
`endif

endmodule

// File: tb/tb_bypass_track_unit.sv
module tb_bypass_track_unit;

    localparam int REG_W   = 5;
    localparam int DEPTH   = 2;
    localparam int NUM_SRC = 2;
    localparam int SEL_W   = 2;

    logic                     clk;
    logic                     rst_n;
    logic                     issue_valid;
    logic [REG_W-1:0]         issue_rd;
    logic                     issue_regw;
    logic                     issue_load;
    logic                     flush;
    logic [NUM_SRC*REG_W-1:0] rs_ex;
    logic [NUM_SRC*REG_W-1:0] rs_dec;
    logic [NUM_SRC*SEL_W-1:0] fwd_sel;
    logic                     stall;
`ifdef BYPASS_STALL_CNT_EN
    logic [31:0]              stall_count;
`endif

    bypass_track_unit #(
        .REG_W(REG_W), .DEPTH(DEPTH), .NUM_SRC(NUM_SRC), .SEL_W(SEL_W)
    ) dut (
        .i_clock       (clk),
        .i_reset_n     (rst_n),
        .i_issue_valid (issue_valid),
        .i_issue_rd    (issue_rd),
        .i_issue_regw  (issue_regw),
        .i_issue_load  (issue_load),
        .i_flush       (flush),
        .i_rs_ex       (rs_ex),
        .i_rs_dec      (rs_dec),
        .o_fwd_sel     (fwd_sel),
        .o_stall       (stall)
`ifdef BYPASS_STALL_CNT_EN
        ,
        .o_stall_count (stall_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [3:0]  fwd;
        logic        stl;
        bit          has_cnt;
        logic [31:0] cnt;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // Monitor: outputs are sampled on the falling edge, away from the
    // active clock edge.
    always @(negedge clk) begin
        while (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            n_tests++;
            if (fwd_sel !== e.fwd) begin
                n_fail++;
                $display("FAIL %s fwd_sel: got %b expected %b", e.name, fwd_sel, e.fwd);
            end
            n_tests++;
            if (stall !== e.stl) begin
                n_fail++;
                $display("FAIL %s stall: got %b expected %b", e.name, stall, e.stl);
            end
`ifdef BYPASS_STALL_CNT_EN
            if (e.has_cnt) begin
                n_tests++;
                if (stall_count !== e.cnt) begin
                    n_fail++;
                    $display("FAIL %s stall_count: got %0d expected %0d", e.name, stall_count, e.cnt);
                end
            end
`endif
        end
    end

    task automatic drive(input logic v, input logic [4:0] rd, input logic rw,
                         input logic ld, input logic fl,
                         input logic [4:0] ex1, input logic [4:0] ex0,
                         input logic [4:0] dc1, input logic [4:0] dc0);
        issue_valid = v;
        issue_rd    = rd;
        issue_regw  = rw;
        issue_load  = ld;
        flush       = fl;
        rs_ex       = {ex1, ex0};
        rs_dec      = {dc1, dc0};
    endtask

    task automatic idle(input logic [4:0] ex1, input logic [4:0] ex0);
        drive(1'b0, 5'd0, 1'b0, 1'b0, 1'b0, ex1, ex0, 5'd0, 5'd0);
    endtask

    // Expected {fwd_sel[1], fwd_sel[0]} and stall for the current inputs.
    task automatic chk(input string name, input logic [3:0] f, input logic s);
        exp_t e;
        e.name = name; e.fwd = f; e.stl = s; e.has_cnt = 1'b0; e.cnt = '0;
        exp_q.push_back(e);
        @(negedge clk);
    endtask

    task automatic chk_cnt(input string name, input logic [3:0] f, input logic s,
                           input logic [31:0] c);
        exp_t e;
        e.name = name; e.fwd = f; e.stl = s; e.has_cnt = 1'b1; e.cnt = c;
        exp_q.push_back(e);
        @(negedge clk);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // 1. Reset forces the outputs low, even with a load-use pattern driven.
        rst_n = 1'b0;
        drive(1'b1, 5'd3, 1'b1, 1'b1, 1'b0, 5'd0, 5'd3, 5'd0, 5'd3);
        chk_cnt("rst_hold", 4'b0000, 1'b0, 32'd0);
        step();
        chk("rst_hold2", 4'b0000, 1'b0);
        step();
        rst_n = 1'b1;
        idle(5'd0, 5'd3);
        chk("rst_release", 4'b0000, 1'b0);
        step();

        // 2. Forward from MEM, then from WB, then from neither.
        drive(1'b1, 5'd3, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 5'd0);
        chk("t2_c0", 4'b0000, 1'b0);
        step();
        idle(5'd3, 5'd3);
        chk("t2_mem", 4'b0101, 1'b0);
        step();
        chk("t2_wb", 4'b1010, 1'b0);
        step();
        chk("t2_gone", 4'b0000, 1'b0);
        step();

        // 3. Youngest match wins.
        drive(1'b1, 5'd4, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 5'd0);
        chk("t3_c0", 4'b0000, 1'b0);
        step();
        drive(1'b1, 5'd4, 1'b1, 1'b0, 1'b0, 5'd4, 5'd0, 5'd0, 5'd0);
        chk("t3_c1", 4'b0100, 1'b0);
        step();
        idle(5'd4, 5'd0);
        chk("t3_prio", 4'b0100, 1'b0);
        step();
        chk("t3_wb_only", 4'b1000, 1'b0);
        step();
        chk("t3_empty", 4'b0000, 1'b0);
        step();

        // 4. x0 and regw=0 writes are never forwarded.
        drive(1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 5'd0);
        chk("t4_c0", 4'b0000, 1'b0);
        step();
        drive(1'b1, 5'd7, 1'b0, 1'b0, 1'b0, 5'd7, 5'd0, 5'd0, 5'd0);
        chk("t4_x0", 4'b0000, 1'b0);
        step();
        idle(5'd7, 5'd0);
        chk("t4_noregw", 4'b0000, 1'b0);
        step();
        drive(1'b1, 5'd0, 1'b1, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 5'd0);
        chk("t4_load_x0", 4'b0000, 1'b0);
        step();
        idle(5'd0, 5'd0);
        step();
        step();

        // 5. Load-use stall.
        drive(1'b1, 5'd5, 1'b1, 1'b1, 1'b0, 5'd0, 5'd0, 5'd5, 5'd0);
        chk("t5_stall", 4'b0000, 1'b1);
        step();
        drive(1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd5, 5'd0);
        chk("t5_bubble", 4'b0000, 1'b0);
        step();
        drive(1'b1, 5'd9, 1'b1, 1'b0, 1'b0, 5'd5, 5'd0, 5'd6, 5'd6);
        chk("t5_use_wb", 4'b1000, 1'b0);
        step();
        drive(1'b1, 5'd5, 1'b1, 1'b1, 1'b0, 5'd0, 5'd0, 5'd6, 5'd6);
        chk("t5_nodep", 4'b0000, 1'b0);
        step();
        idle(5'd0, 5'd0);
        step();
        step();
        drive(1'b1, 5'd5, 1'b1, 1'b1, 1'b1, 5'd0, 5'd0, 5'd5, 5'd0);
        chk("t5_flush", 4'b0000, 1'b0);
        step();
        idle(5'd0, 5'd5);
        chk("t5_flushed", 4'b0000, 1'b0);
        step();
        drive(1'b1, 5'd12, 1'b1, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 5'd12);
        chk("t5_stall_op0", 4'b0000, 1'b1);
        step();
        idle(5'd0, 5'd0);
        chk("t5_bubble2", 4'b0000, 1'b0);
        step();
        drive(1'b1, 5'd13, 1'b1, 1'b1, 1'b0, 5'd0, 5'd0, 5'd13, 5'd0);
        chk("t5_stall3", 4'b0000, 1'b1);
        step();

        // 6. Three stalls are counted, then a mid-run reset clears everything.
        drive(1'b1, 5'd14, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 5'd0);
        chk_cnt("t6_count3", 4'b0000, 1'b0, 32'd3);
        step();
        idle(5'd0, 5'd14);
        chk_cnt("t6_fwd14", 4'b0001, 1'b0, 32'd3);
        #2;
        rst_n = 1'b0;
        drive(1'b1, 5'd14, 1'b1, 1'b1, 1'b0, 5'd0, 5'd14, 5'd0, 5'd14);
        chk_cnt("t6_rst_mid", 4'b0000, 1'b0, 32'd0);
        step();
        rst_n = 1'b1;
        idle(5'd14, 5'd14);
        chk_cnt("t6_after_rst", 4'b0000, 1'b0, 32'd0);
        step();
        chk("t6_after_rst2", 4'b0000, 1'b0);
        #1;

        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
